// File: rtl/key_event_ctrl.sv
// Four-key debouncer with a round-robin scanner that reports press, release and
// long-press events through a 4-entry event FIFO with a sticky overflow flag.
module key_event_ctrl #(
    parameter int TICK_DIV       = 100000,
    parameter int STABLE_SAMPLES = 4,
    parameter int LONG_TICKS     = 50
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] keys_in,
    output logic [3:0] keys_db,
    output logic       ev_valid,
    input  logic       ev_ready,
    output logic [1:0] ev_key,
    output logic [1:0] ev_code,
    output logic       overflow,
    input  logic       clr_ovf
);
    localparam int N_KEYS     = 4;
    localparam int FIFO_DEPTH = 4;
    localparam int PW         = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    typedef enum logic {IDLE = 1'b0, SCAN = 1'b1} state_t;

    state_t          state_reg;
    logic [1:0]      idx_reg;
    logic [PW-1:0]   presc_reg;
    logic            tick;
    logic            scan_active;

    logic [N_KEYS-1:0] sync_all;
    logic [3:0]        stab_all [N_KEYS];
    logic [7:0]        hold_all [N_KEYS];

    logic       cur_sync, cur_db, differ;
    logic [3:0] cur_stab, stab_inc, stab_next;
    logic [7:0] cur_hold, hold_next;
    logic       toggle, long_ev, push;
    logic [1:0] push_code;

    logic [3:0] fifo_mem [FIFO_DEPTH];
    logic [1:0] wr_ptr_reg, rd_ptr_reg;
    logic [2:0] count_reg;
    logic       ovf_reg;
    logic       pop, push_ok, drop;
    logic [3:0] head;

    // Sample-tick prescaler
    always_ff @(posedge clk) begin
        if (rst || presc_reg == PW'(TICK_DIV - 1))
            presc_reg <= '0;
        else
            presc_reg <= presc_reg + 1'b1;
    end
    assign tick = (presc_reg == PW'(TICK_DIV - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            idx_reg   <= 2'd0;
        end else begin
            case (state_reg)
                IDLE: if (tick) begin
                    state_reg <= SCAN;
                    idx_reg   <= 2'd0;
                end
                SCAN: begin
                    idx_reg <= idx_reg + 2'd1;
                    if (idx_reg == 2'd3) state_reg <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end
    assign scan_active = (state_reg == SCAN);

    genvar gi;
    generate
        for (gi = 0; gi < N_KEYS; gi++) begin : g_key
            logic       sync1_reg, sync2_reg, db_reg;
            logic [3:0] stab_reg;
            logic [7:0] hold_reg;

            always_ff @(posedge clk) begin
                if (rst) begin
                    sync1_reg <= 1'b0;
                    sync2_reg <= 1'b0;
                    db_reg    <= 1'b0;
                    stab_reg  <= 4'd0;
                    hold_reg  <= 8'd0;
                end else begin
                    sync1_reg <= keys_in[gi];
                    sync2_reg <= sync1_reg;
                    if (scan_active && idx_reg == 2'(gi)) begin
                        stab_reg <= stab_next;
                        hold_reg <= hold_next;
                        if (toggle) db_reg <= ~db_reg;
                    end
                end
            end

            assign sync_all[gi] = sync2_reg;
            assign keys_db[gi]  = db_reg;
            assign stab_all[gi] = stab_reg;
            assign hold_all[gi] = hold_reg;
        end
    endgenerate

    // Shared per-key update logic for whichever key is being scanned this cycle
    always_comb begin
        cur_sync  = sync_all[idx_reg];
        cur_db    = keys_db[idx_reg];
        cur_stab  = stab_all[idx_reg];
        cur_hold  = hold_all[idx_reg];
        differ    = cur_sync ^ cur_db;
        stab_inc  = cur_stab + 4'd1;
        toggle    = scan_active && differ && (stab_inc == 4'(STABLE_SAMPLES));
        stab_next = (differ && !toggle) ? stab_inc : 4'd0;
        hold_next = cur_hold;
        if (toggle || !cur_db)
            hold_next = 8'd0;
        else if (cur_hold < 8'(LONG_TICKS))
            hold_next = cur_hold + 8'd1;
        // The toggle event wins, so a long event can never share a scan with an edge event
        long_ev   = scan_active && cur_db && !toggle && (cur_hold == 8'(LONG_TICKS - 1));
        push      = toggle || long_ev;
        push_code = toggle ? {1'b0, cur_db} : 2'b10;
    end

    assign pop     = (count_reg != 3'd0) && ev_ready;
    assign push_ok = push && ((count_reg != 3'(FIFO_DEPTH)) || pop);
    assign drop    = push && !push_ok;

    always_ff @(posedge clk) begin
        if (push_ok) fifo_mem[wr_ptr_reg] <= {idx_reg, push_code};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg <= 2'd0;
            rd_ptr_reg <= 2'd0;
            count_reg  <= 3'd0;
            ovf_reg    <= 1'b0;
        end else begin
            if (push_ok) wr_ptr_reg <= wr_ptr_reg + 2'd1;
            if (pop)     rd_ptr_reg <= rd_ptr_reg + 2'd1;
            count_reg <= count_reg + 3'(push_ok) - 3'(pop);
            if (drop)
                ovf_reg <= 1'b1;
            else if (clr_ovf)
                ovf_reg <= 1'b0;
        end
    end

    // Head is masked while empty so the outputs read zero after reset
    assign head     = fifo_mem[rd_ptr_reg];
    assign ev_valid = (count_reg != 3'd0);
    assign ev_key   = ev_valid ? head[3:2] : 2'd0;
    assign ev_code  = ev_valid ? head[1:0] : 2'd0;
    assign overflow = ovf_reg;
endmodule

// File: tb/tb_key_event_ctrl.sv
// Directed bench for key_event_ctrl: reset, bounce, press/long/release, overflow,
// full-with-pop and reset in the middle of a scan.
module tb_key_event_ctrl;
    logic       clk = 1'b0;
    logic       rst, ev_ready, clr_ovf;
    logic [3:0] keys_in, keys_db;
    logic       ev_valid, overflow;
    logic [1:0] ev_key, ev_code;

    int     n_checks = 0;
    int     n_fail   = 0;
    longint cyc      = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    key_event_ctrl #(.TICK_DIV(8), .STABLE_SAMPLES(4), .LONG_TICKS(3)) dut (
        .clk(clk), .rst(rst), .keys_in(keys_in), .keys_db(keys_db),
        .ev_valid(ev_valid), .ev_ready(ev_ready), .ev_key(ev_key),
        .ev_code(ev_code), .overflow(overflow), .clr_ovf(clr_ovf)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end else begin
            $display("ok   %s: %0h", tag, got);
        end
    endtask

    task automatic wait_event(input string tag, output longint t);
        int n = 0;
        while (!ev_valid && n < 300) begin
            @(negedge clk);
            n++;
        end
        check({tag, " arrives"}, 32'(ev_valid), 32'd1);
        t = cyc;
    endtask

    task automatic pop_expect(input string tag, input logic [1:0] k, input logic [1:0] c);
        check({tag, " key"}, 32'(ev_key), 32'(k));
        check({tag, " code"}, 32'(ev_code), 32'(c));
        ev_ready = 1'b1;
        @(negedge clk);
        ev_ready = 1'b0;
    endtask

    // Press, long press three ticks (24 cycles) later, no repeat, then release
    task automatic run_key(input int k);
        longint t0, t1, tr;
        bit     seen;
        keys_in[k] = 1'b1;
        wait_event($sformatf("k%0d press", k), t0);
        check($sformatf("k%0d db after press", k), 32'(keys_db), 32'(4'b0001 << k));
        pop_expect($sformatf("k%0d press", k), 2'(k), 2'b00);
        wait_event($sformatf("k%0d long", k), t1);
        check($sformatf("k%0d long delay", k), 32'(t1 - t0), 32'd24);
        pop_expect($sformatf("k%0d long", k), 2'(k), 2'b10);
        seen = 1'b0;
        repeat (80) begin
            @(negedge clk);
            if (ev_valid) seen = 1'b1;
        end
        check($sformatf("k%0d single long", k), 32'(seen), 32'd0);
        keys_in[k] = 1'b0;
        wait_event($sformatf("k%0d release", k), tr);
        check($sformatf("k%0d db after release", k), 32'(keys_db), 32'd0);
        pop_expect($sformatf("k%0d release", k), 2'(k), 2'b01);
    endtask

    initial begin
        bit     seen;
        int     n;
        longint t;

        rst = 1'b1; keys_in = 4'hF; ev_ready = 1'b0; clr_ovf = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst keys_db", 32'(keys_db), 32'd0);
        check("rst ev_valid", 32'(ev_valid), 32'd0);
        check("rst ev_key", 32'(ev_key), 32'd0);
        check("rst ev_code", 32'(ev_code), 32'd0);
        check("rst overflow", 32'(overflow), 32'd0);
        keys_in = 4'h0;

        // Bounce: key0 toggles every 5 cycles, never stable for 4 ticks
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            keys_in[0] = ~keys_in[0];
            repeat (5) begin
                @(negedge clk);
                if (ev_valid || keys_db[0]) seen = 1'b1;
            end
        end
        repeat (80) begin
            @(negedge clk);
            if (ev_valid || keys_db[0]) seen = 1'b1;
        end
        check("bounce no event", 32'(seen), 32'd0);

        run_key(1);
        run_key(2);

        // Overflow: 4 presses fill the FIFO, the long events that follow are dropped
        keys_in = 4'hF;
        wait_event("ovf first press", t);
        repeat (56) @(negedge clk);
        check("ovf ev_valid", 32'(ev_valid), 32'd1);
        check("ovf overflow", 32'(overflow), 32'd1);
        check("ovf keys_db", 32'(keys_db), 32'hF);
        clr_ovf = 1'b1;
        @(negedge clk);
        clr_ovf = 1'b0;
        check("ovf cleared", 32'(overflow), 32'd0);
        for (int k = 0; k < 3; k++) pop_expect($sformatf("ovf entry%0d", k), 2'(k), 2'b00);

        // Full-with-pop: release all; pop the last press exactly when release3 is pushed
        keys_in = 4'h0;
        n = 0;
        while (keys_db[2] && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("fwp keys_db before", 32'(keys_db), 32'h8);
        ev_ready = 1'b1;
        @(negedge clk);
        ev_ready = 1'b0;
        check("fwp overflow", 32'(overflow), 32'd0);
        check("fwp keys_db after", 32'(keys_db), 32'd0);
        for (int k = 0; k < 4; k++) pop_expect($sformatf("fwp entry%0d", k), 2'(k), 2'b01);
        check("fwp drained", 32'(ev_valid), 32'd0);

        // Reset while scanning idx=2 with a pending event and key3 down
        keys_in = 4'h8;
        wait_event("mid press", t);
        check("mid head key", 32'(ev_key), 32'd3);
        n = 0;
        while (!(dut.state_reg == 1'b1 && dut.idx_reg == 2'd2) && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("mid found idx2", 32'(n < 100), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mid keys_db", 32'(keys_db), 32'd0);
        check("mid ev_valid", 32'(ev_valid), 32'd0);
        check("mid ev_key", 32'(ev_key), 32'd0);
        check("mid ev_code", 32'(ev_code), 32'd0);
        check("mid overflow", 32'(overflow), 32'd0);
        check("mid state idle", 32'(dut.state_reg), 32'd0);
        check("mid idx", 32'(dut.idx_reg), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/key_event_ctrl.md
KEY_EVENT_CTRL -- requirements
Module: key_event_ctrl

Interface
REQ-001 SHALL have parameter TICK_DIV, default 100000, meaning clk cycles per sample tick (legal minimum 8).
REQ-002 SHALL have parameter STABLE_SAMPLES, default 4, meaning consecutive differing ticks needed to flip a debounced level (range 1..15).
REQ-003 SHALL have parameter LONG_TICKS, default 50, meaning held ticks before a long-press event (range 1..255).
REQ-004 SHALL have fixed constants N_KEYS = 4 and FIFO_DEPTH = 4.
REQ-005 SHALL have port clk, input, 1, the single clock; all logic on posedge clk.
REQ-006 SHALL have port rst, input, 1; reset is synchronous and active-high.
REQ-007 SHALL have port keys_in, input, 4, raw asynchronous active-high key lines.
REQ-008 SHALL have port keys_db, output, 4, debounced key levels.
REQ-009 SHALL have port ev_valid, output, 1, high when the event FIFO is non-empty.
REQ-010 SHALL have port ev_ready, input, 1, consumer accepts the head event.
REQ-011 SHALL have port ev_key, output, 2, key index of the head event.
REQ-012 SHALL have port ev_code, output, 2, head event type: 00 press, 01 release, 10 long; 11 never produced.
REQ-013 SHALL have port overflow, output, 1, sticky flag set when an event is dropped.
REQ-014 SHALL have port clr_ovf, input, 1, clears overflow.

Function
REQ-015 SHALL pass each keys_in bit through a 2-flop synchronizer before any use.
REQ-016 SHALL run a prescaler counting 0..TICK_DIV-1 with wrap to 0, and SHALL assert an internal tick for one cycle when it equals TICK_DIV-1.
REQ-017 SHALL run a scan FSM with states IDLE and SCAN: IDLE->SCAN on tick with idx=0; in SCAN, process key idx, then increment idx; SCAN->IDLE after idx=3; exactly one key per cycle.
REQ-018 SHALL, for the scanned key, increment its 4-bit stable counter when the synchronized input differs from keys_db[idx], and otherwise clear that counter to 0.
REQ-019 SHALL, when the incremented stable counter equals STABLE_SAMPLES, toggle keys_db[idx], clear the counter, and push a press (0->1) or release (1->0) event.
REQ-020 SHALL keep a per-key 8-bit hold counter that increments at the key's scan while keys_db[idx]=1, saturates at LONG_TICKS, and is cleared while keys_db[idx]=0.
REQ-021 SHALL push exactly one long event when the hold counter transitions to LONG_TICKS; a long event SHALL never be generated on the same scan as that key's press.
REQ-022 SHALL push at most one event per clock cycle.
REQ-023 SHALL place a pushed event in the FIFO on the scan cycle, so that ev_valid rises on the next cycle when the FIFO was empty.
REQ-024 SHALL present the FIFO head on ev_key and ev_code while ev_valid=1, and SHALL hold those outputs stable until popped.
REQ-025 SHALL pop the head on any cycle with ev_valid=1 and ev_ready=1; ev_ready while empty SHALL have no effect.
REQ-026 SHALL accept a push when fewer than 4 entries are held, or when the FIFO holds 4 and a pop occurs in the same cycle.
REQ-027 SHALL otherwise drop the pushed event, leave the FIFO unchanged, and set overflow.
REQ-028 SHALL clear overflow on clr_ovf=1, except that a same-cycle drop SHALL take priority and leave overflow set.
REQ-029 SHALL wrap FIFO read and write pointers modulo 4, with a separate 3-bit occupancy count.
REQ-030 SHALL toggle keys_db on a full FIFO even when the corresponding event is dropped.

Reset
REQ-031 SHALL, on rst=1 at a clock edge, clear the prescaler, synchronizers, all stable and hold counters, keys_db, FIFO pointers and count, and overflow, and SHALL force the FSM to IDLE with idx=0.
REQ-032 SHALL drive keys_db=0, ev_valid=0, ev_key=0, ev_code=0 and overflow=0 in the cycle after reset, with no events generated for keys already high.
REQ-033 SHALL apply reset in the middle of a scan by aborting that scan without pushing a partial event.

Verification
REQ-034 SHALL cover clean press: TICK_DIV=8, STABLE_SAMPLES=4, key1 held high -> keys_db[1]=1 after 4 ticks, then one event ev_key=1, ev_code=00.
REQ-035 SHALL cover bounce: key0 toggles every 5 cycles for 100 cycles, then stays low -> keys_db[0] stays 0 and no event is produced.
REQ-036 SHALL cover long press: LONG_TICKS=3, key2 held -> press, then exactly one ev_code=10 three ticks later; release -> ev_code=01.
REQ-037 SHALL cover overflow: ev_ready=0 with 5 events generated -> ev_valid=1, 4 entries held, overflow=1, 5th event lost; clr_ovf -> overflow=0.
REQ-038 SHALL cover full-with-pop: FIFO full and ev_ready=1 on a push cycle -> push accepted, occupancy stays 4, overflow=0.
REQ-039 SHALL cover reset mid-scan: rst=1 in SCAN with idx=2 -> next cycle all outputs 0, FSM IDLE, FIFO empty.
